// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: bitslip word alignment on control tokens, then 10b->8b decode.
module tmds_channel_decoder #(
    parameter int TOKEN_COUNT    = 64,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 8
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic       bitslip,
    output logic       aligned,
    output logic [3:0] slip_cnt,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [16:0] TOKEN_LIM   = 17'(TOKEN_COUNT);
    localparam logic [16:0] TIMEOUT_LIM = 17'(SEARCH_TIMEOUT);
    localparam logic [16:0] WAIT_LIM    = 17'(SLIP_WAIT);

    // {valid, ctrl} for the four DVI control tokens
    function automatic logic [2:0] token_decode(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    state_t      state, state_nx;
    logic [15:0] run, run_nx;
    logic [15:0] timer, timer_nx;
    logic [15:0] gap, gap_nx;
    logic [15:0] wait_cnt, wait_nx;
    logic [3:0]  slip_nx;
    logic [16:0] run_inc, timer_inc, gap_inc, wait_inc;
    logic [2:0]  raw_tok_info;
    logic        raw_tok;

    assign raw_tok_info = token_decode(raw_word);
    assign raw_tok      = raw_tok_info[2];
    assign run_inc      = {1'b0, run} + 17'd1;
    assign timer_inc    = {1'b0, timer} + 17'd1;
    assign gap_inc      = {1'b0, gap} + 17'd1;
    assign wait_inc     = {1'b0, wait_cnt} + 17'd1;

    always_comb begin
        state_nx = state;
        run_nx   = run;
        timer_nx = timer;
        gap_nx   = gap;
        wait_nx  = wait_cnt;
        slip_nx  = slip_cnt;
        case (state)
            SEARCH: begin
                timer_nx = timer_inc[15:0];
                run_nx   = raw_tok ? run_inc[15:0] : 16'd0;
                // a completed token run wins over a simultaneous timeout
                if (raw_tok && run_inc >= TOKEN_LIM) begin
                    state_nx = LOCKED;
                    run_nx   = 16'd0;
                    timer_nx = 16'd0;
                    gap_nx   = 16'd0;
                end else if (timer_inc >= TIMEOUT_LIM) begin
                    state_nx = SLIP;
                    run_nx   = 16'd0;
                    timer_nx = 16'd0;
                    slip_nx  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                end
            end
            SLIP: begin
                state_nx = WAIT;
                wait_nx  = 16'd0;
            end
            WAIT: begin
                wait_nx = wait_inc[15:0];
                if (wait_inc >= WAIT_LIM) begin
                    state_nx = SEARCH;
                    wait_nx  = 16'd0;
                    run_nx   = 16'd0;
                    timer_nx = 16'd0;
                end
            end
            LOCKED: begin
                gap_nx = raw_tok ? 16'd0 : gap_inc[15:0];
                if (!raw_tok && gap_inc >= TIMEOUT_LIM) begin
                    state_nx = SEARCH;
                    gap_nx   = 16'd0;
                    run_nx   = 16'd0;
                    timer_nx = 16'd0;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state    <= SEARCH;
            run      <= 16'd0;
            timer    <= 16'd0;
            gap      <= 16'd0;
            wait_cnt <= 16'd0;
            slip_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            run      <= run_nx;
            timer    <= timer_nx;
            gap      <= gap_nx;
            wait_cnt <= wait_nx;
            slip_cnt <= slip_nx;
        end
    end

    assign bitslip = (state == SLIP);
    assign aligned = (state == LOCKED);

    // two word registers ahead of the decode register give the fixed 2-edge latency
    logic [9:0] word_d1, word_d2;
    logic [2:0] pipe_tok_info;
    logic       de_q;
    logic [1:0] ctrl_q;
    logic [7:0] data_q;

    assign pipe_tok_info = token_decode(word_d2);

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            word_d1 <= 10'd0;
            word_d2 <= 10'd0;
            de_q    <= 1'b0;
            ctrl_q  <= 2'd0;
            data_q  <= 8'd0;
        end else begin
            word_d1 <= raw_word;
            word_d2 <= word_d1;
            if (pipe_tok_info[2]) begin
                de_q   <= 1'b0;
                ctrl_q <= pipe_tok_info[1:0];
                data_q <= 8'd0;
            end else begin
                de_q   <= 1'b1;
                data_q <= tmds_decode(word_d2);
            end
        end
    end

    assign de   = aligned & de_q;
    assign ctrl = aligned ? ctrl_q : 2'd0;
    assign data = aligned ? data_q : 8'd0;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - randomized bench for tmds_channel_decoder with a behavioural reference model.
module tb_tmds_channel_decoder;

    localparam int TC = 16;
    localparam int TO = 256;
    localparam int SW = 8;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic       bitslip;
    logic       aligned;
    logic [3:0] slip_cnt;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;

    tmds_channel_decoder #(
        .TOKEN_COUNT   (TC),
        .SEARCH_TIMEOUT(TO),
        .SLIP_WAIT     (SW)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst      (rst),
        .raw_word (raw_word),
        .bitslip  (bitslip),
        .aligned  (aligned),
        .slip_cnt (slip_cnt),
        .de       (de),
        .ctrl     (ctrl),
        .data     (data)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [9:0] tok_tbl [4];
    initial begin
        tok_tbl[0] = 10'b1101010100;
        tok_tbl[1] = 10'b0010101011;
        tok_tbl[2] = 10'b0101010100;
        tok_tbl[3] = 10'b1010101011;
    end

    function automatic int tok_code(input logic [9:0] w);
        int c;
        c = -1;
        for (int i = 0; i < 4; i++) if (tok_tbl[i] == w) c = i;
        return c;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] d, x;
        d = w[9] ? ~w[7:0] : w[7:0];
        x = d ^ {d[6:0], 1'b0};
        if (!w[8]) x[7:1] = ~x[7:1];
        return x;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        while (tok_code(w) >= 0) w = 10'($urandom);
        return w;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] dbl;
        dbl = {w, w} >> k;
        return dbl[9:0];
    endfunction

    // reference model state
    logic       m_locked = 1'b0, m_slip = 1'b0, m_de = 1'b0;
    int         m_run = 0, m_age = 0, m_gap = 0, m_settle = 0, m_slips = 0;
    logic [1:0] m_hold = 2'd0;
    logic [7:0] m_data = 8'd0;
    logic [9:0] m_pipe [$];
    int         edges = 0;
    int         offset = 0;

    task automatic model_step(input logic [9:0] w, input logic r);
        logic [9:0] pw;
        logic       tk;
        int         c;
        if (r) begin
            m_locked = 1'b0; m_slip = 1'b0; m_de = 1'b0;
            m_run = 0; m_age = 0; m_gap = 0; m_settle = 0; m_slips = 0;
            m_hold = 2'd0; m_data = 8'd0;
            m_pipe.delete();
            m_pipe.push_back(10'd0);
            m_pipe.push_back(10'd0);
        end else begin
            tk = (tok_code(w) >= 0);
            if (m_locked) begin
                m_gap = tk ? 0 : m_gap + 1;
                if (m_gap == TO) begin m_locked = 1'b0; m_age = 0; m_run = 0; end
            end else if (m_slip) begin
                m_slip = 1'b0;
                m_settle = SW;
            end else if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) begin m_age = 0; m_run = 0; end
            end else begin
                m_age++;
                m_run = tk ? m_run + 1 : 0;
                if (m_run == TC) begin
                    m_locked = 1'b1; m_gap = 0;
                end else if (m_age == TO) begin
                    m_slip = 1'b1; m_age = 0; m_run = 0;
                    m_slips = (m_slips + 1) % 10;
                end
            end
            m_pipe.push_back(w);
            pw = m_pipe.pop_front();
            c = tok_code(pw);
            if (c >= 0) begin
                m_de = 1'b0; m_hold = 2'(c); m_data = 8'd0;
            end else begin
                m_de = 1'b1; m_data = ref_decode(pw);
            end
        end
    endtask

    task automatic tick(input logic [9:0] w, input logic r);
        logic bs_before;
        @(negedge clk_pixel);
        raw_word = w;
        rst = r;
        bs_before = bitslip;
        @(posedge clk_pixel);
        // deserializer moves its word boundary back one bit per honoured request
        if (bs_before) offset = (offset == 0) ? 9 : offset - 1;
        model_step(w, r);
        if (r) edges = 0; else edges++;
        #1;
        check("bitslip",  32'(bitslip),  32'(m_slip));
        check("aligned",  32'(aligned),  32'(m_locked));
        check("slip_cnt", 32'(slip_cnt), 32'(m_slips));
        check("de",       32'(de),       32'(m_locked & m_de));
        check("ctrl",     32'(ctrl),     32'(m_locked ? m_hold : 2'd0));
        check("data",     32'(data),     32'(m_locked ? m_data : 8'd0));
    endtask

    task automatic wait_slip(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(rand_data(), 1'b0);
            if (bitslip) begin
                at = edges;
                break;
            end
        end
    endtask

    initial begin
        int at, at2, e0, gap_run;
        logic [9:0] w;
        m_pipe.push_back(10'd0);
        m_pipe.push_back(10'd0);

        // reset and search timeouts on a token-free stream
        for (int i = 0; i < 3; i++) tick(10'($urandom), 1'b1);
        check("reset_outputs", 32'({bitslip, aligned, slip_cnt, de, ctrl, data}), 32'd0);
        for (int i = 0; i < TO - 1; i++) tick(rand_data(), 1'b0);
        check("no_early_slip", 32'(bitslip), 32'd0);
        wait_slip(20, at);
        check("first_slip_edge", 32'(at), 32'(TO));
        for (int k = 1; k < 12; k++) begin
            wait_slip(400, at2);
            check("slip_period", 32'(at2 - at), 32'(TO + 1 + SW));
            at = at2;
        end
        check("slip_wrap", 32'(slip_cnt), 32'd2);

        // lock on a token run, then decode
        tick(rand_data(), 1'b1);
        tick(rand_data(), 1'b1);
        for (int i = 0; i < TC - 1; i++) tick(tok_tbl[0], 1'b0);
        check("not_yet_aligned", 32'(aligned), 32'd0);
        tick(tok_tbl[0], 1'b0);
        check("lock_edge", 32'(aligned), 32'd1);
        tick(10'h100, 1'b0);
        tick(10'h1FF, 1'b0);
        tick(tok_tbl[0], 1'b0);
        check("dec_100", 32'({de, data}), 32'h100);
        tick(tok_tbl[1], 1'b0);
        check("dec_1ff", 32'({de, data}), 32'h101);
        tick(tok_tbl[2], 1'b0);
        check("ctrl_00", 32'({de, ctrl, data}), 32'h000);
        tick(tok_tbl[3], 1'b0);
        check("ctrl_01", 32'({de, ctrl, data}), 32'h100);
        tick(rand_data(), 1'b0);
        check("ctrl_10", 32'({de, ctrl, data}), 32'h200);
        tick(rand_data(), 1'b0);
        check("ctrl_11", 32'({de, ctrl, data}), 32'h300);
        tick(rand_data(), 1'b0);
        check("ctrl_hold", 32'({de, ctrl}), 32'b111);

        // random mix of pixels and tokens while locked
        gap_run = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0 || gap_run > 60) begin
                w = tok_tbl[$urandom_range(3)];
                gap_run = 0;
            end else begin
                w = rand_data();
                gap_run++;
            end
            tick(w, 1'b0);
        end

        // loss of lock after a full timeout of data words
        tick(tok_tbl[$urandom_range(3)], 1'b0);
        for (int i = 0; i < TO - 1; i++) tick(rand_data(), 1'b0);
        check("still_aligned", 32'(aligned), 32'd1);
        tick(rand_data(), 1'b0);
        check("lock_lost", 32'({aligned, de, data}), 32'd0);
        e0 = edges;
        wait_slip(400, at);
        check("slip_after_loss", 32'(at - e0), 32'(TO));

        // misaligned stream: three slips to recover
        tick(rand_data(), 1'b1);
        tick(rand_data(), 1'b1);
        offset = 3;
        for (int i = 0; i < 2000 && !aligned; i++) tick(rot(tok_tbl[0], offset), 1'b0);
        check("misalign_lock", 32'(aligned), 32'd1);
        check("misalign_slips", 32'(slip_cnt), 32'd3);
        for (int i = 0; i < 300; i++) tick(rot(tok_tbl[0], offset), 1'b0);
        check("no_more_slips", 32'({aligned, slip_cnt}), 32'h13);

        // reset while in SLIP
        tick(rand_data(), 1'b1);
        wait_slip(400, at);
        check("slip_seen", 32'(at), 32'(TO));
        tick(rand_data(), 1'b1);
        check("rst_in_slip", 32'({bitslip, slip_cnt, aligned}), 32'd0);
        wait_slip(400, at);
        check("restart_after_slip_rst", 32'(at), 32'(TO));

        // reset while in WAIT
        for (int i = 0; i < 3; i++) tick(rand_data(), 1'b0);
        tick(rand_data(), 1'b1);
        check("rst_in_wait", 32'({bitslip, slip_cnt, aligned}), 32'd0);
        wait_slip(400, at);
        check("restart_after_wait_rst", 32'(at), 32'(TO));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
